// File: rtl/ps2mouse_ctrlmod.sv
// PS/2 mouse packet sequencer: turns 32-bit packets into a clamped cursor,
// saturating wheel count and button state, with a no-packet re-init watchdog.
module ps2mouse_ctrlmod #(
  parameter int CW      = 11,
  parameter int X_MAX   = 639,
  parameter int Y_MAX   = 479,
  parameter int X_INIT  = 320,
  parameter int Y_INIT  = 240,
  parameter int TIMEOUT = 50_000_000
) (
  input  logic          CLOCK,
  input  logic          RESET,
  input  logic          iEn,
  input  logic          iTrig,
  input  logic [31:0]   iData,
  output logic [CW-1:0] oX,
  output logic [CW-1:0] oY,
  output logic [7:0]    oZ,
  output logic [2:0]    oBtn,
  output logic          oDone,
  output logic          oReinit,
  output logic          oOvr
);
  localparam int NW  = CW + 2;
  localparam int WDW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {WAIT_EN, IDLE, CALC, CLAMP, UPDATE} state_e;

  state_e                state_q;
  logic [WDW-1:0]        wd_q;
  logic signed [8:0]     dx_q, dy_q, dx_d, dy_d;
  logic signed [3:0]     dz_q;
  logic [2:0]            btn_q;
  logic signed [NW-1:0]  nx_q, ny_q, nx_d, ny_d;
  logic signed [8:0]     wz_q, wz_d;
  logic [CW-1:0]         cx_q, cy_q, cx_d, cy_d;
  logic [7:0]            cz_q, cz_d;

  // Bit 3 (always-one) and the top nibble carry no information.
  logic unused_bits;
  assign unused_bits = ^{iData[31:28], iData[3]};

  always_comb begin
    dx_d = iData[6] ? 9'sd0 : $signed({iData[4], iData[15:8]});
    dy_d = iData[7] ? 9'sd0 : $signed({iData[5], iData[23:16]});
    // Widened by two bits so the sum can neither wrap nor lose its sign.
    nx_d = $signed({2'b00, oX} + {{(NW-9){dx_q[8]}}, dx_q});
    ny_d = $signed({2'b00, oY} - {{(NW-9){dy_q[8]}}, dy_q});
    wz_d = $signed({oZ[7], oZ} + {{5{dz_q[3]}}, dz_q});

    if (nx_q < 0)                cx_d = '0;
    else if (nx_q > NW'(X_MAX))  cx_d = CW'(X_MAX);
    else                         cx_d = nx_q[CW-1:0];

    if (ny_q < 0)                cy_d = '0;
    else if (ny_q > NW'(Y_MAX))  cy_d = CW'(Y_MAX);
    else                         cy_d = ny_q[CW-1:0];

    if (wz_q > 9'sd127)          cz_d = 8'd127;
    else if (wz_q < -9'sd127)    cz_d = 8'h81;
    else                         cz_d = wz_q[7:0];
  end

  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      state_q <= WAIT_EN;
      wd_q    <= '0;
      dx_q    <= '0;
      dy_q    <= '0;
      dz_q    <= '0;
      btn_q   <= '0;
      nx_q    <= '0;
      ny_q    <= '0;
      wz_q    <= '0;
      cx_q    <= '0;
      cy_q    <= '0;
      cz_q    <= '0;
      oX      <= CW'(X_INIT);
      oY      <= CW'(Y_INIT);
      oZ      <= '0;
      oBtn    <= '0;
      oDone   <= 1'b0;
      oReinit <= 1'b0;
      oOvr    <= 1'b0;
    end else begin
      oDone   <= 1'b0;
      oReinit <= 1'b0;
      if (iTrig && (state_q == CALC || state_q == CLAMP || state_q == UPDATE))
        oOvr <= 1'b1;

      if (state_q == WAIT_EN) begin
        if (iEn) state_q <= IDLE;
      end else if (!iEn) begin
        // Enable loss outranks packets and watchdog expiry alike.
        state_q <= WAIT_EN;
        wd_q    <= '0;
      end else begin
        case (state_q)
          IDLE: begin
            if (iTrig) begin
              dx_q    <= dx_d;
              dy_q    <= dy_d;
              dz_q    <= $signed(iData[27:24]);
              btn_q   <= iData[2:0];
              wd_q    <= '0;
              state_q <= CALC;
            end else if (wd_q == WDW'(TIMEOUT - 1)) begin
              oReinit <= 1'b1;
              wd_q    <= '0;
              state_q <= WAIT_EN;
            end else begin
              wd_q <= wd_q + WDW'(1);
            end
          end
          CALC: begin
            nx_q    <= nx_d;
            ny_q    <= ny_d;
            wz_q    <= wz_d;
            state_q <= CLAMP;
          end
          CLAMP: begin
            cx_q    <= cx_d;
            cy_q    <= cy_d;
            cz_q    <= cz_d;
            state_q <= UPDATE;
          end
          UPDATE: begin
            oX      <= cx_q;
            oY      <= cy_q;
            oZ      <= cz_q;
            oBtn    <= btn_q;
            oDone   <= 1'b1;
            state_q <= IDLE;
          end
          default: state_q <= WAIT_EN;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_ps2mouse_ctrlmod.sv
// Directed bench for ps2mouse_ctrlmod: a cycle-level behavioural model checked
// every cycle, plus literal expectations for the listed scenarios.
module tb_ps2mouse_ctrlmod;
  localparam int CW = 11, X_MAX = 639, Y_MAX = 479, X_INIT = 320, Y_INIT = 240;
  localparam int TO = 100;

  logic          CLOCK = 1'b0;
  logic          RESET = 1'b1;
  logic          iEn   = 1'b0;
  logic          iTrig = 1'b0;
  logic [31:0]   iData = '0;
  logic [CW-1:0] oX, oY;
  logic [7:0]    oZ;
  logic [2:0]    oBtn;
  logic          oDone, oReinit, oOvr;

  int n_vec = 0;
  int n_err = 0;
  int reinit_cnt = 0;
  bit chk_en = 1'b0;

  ps2mouse_ctrlmod #(.CW(CW), .X_MAX(X_MAX), .Y_MAX(Y_MAX), .X_INIT(X_INIT),
                     .Y_INIT(Y_INIT), .TIMEOUT(TO)) dut (
    .CLOCK(CLOCK), .RESET(RESET), .iEn(iEn), .iTrig(iTrig), .iData(iData),
    .oX(oX), .oY(oY), .oZ(oZ), .oBtn(oBtn), .oDone(oDone),
    .oReinit(oReinit), .oOvr(oOvr));

  always #5 CLOCK = ~CLOCK;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t",
               nm, $signed(act), act, $signed(exp), exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  int  m_x, m_y, m_z, m_btn;
  bit  m_done, m_reinit, m_ovr;
  bit  m_on;          // stream enabled (left the wait-for-enable phase)
  int  m_busy;        // edges left until the pending packet lands
  int  m_wd;          // consecutive idle edges without a packet
  logic [31:0] m_pkt;

  function automatic int clampi(input int v, input int lo, input int hi);
    return (v < lo) ? lo : (v > hi) ? hi : v;
  endfunction

  task automatic m_apply(input logic [31:0] p);
    int dx, dy, dz;
    dx = p[6] ? 0 : (p[4] ? int'(p[15:8]) - 256 : int'(p[15:8]));
    dy = p[7] ? 0 : (p[5] ? int'(p[23:16]) - 256 : int'(p[23:16]));
    dz = (int'(p[27:24]) >= 8) ? int'(p[27:24]) - 16 : int'(p[27:24]);
    m_x   = clampi(m_x + dx, 0, X_MAX);
    m_y   = clampi(m_y - dy, 0, Y_MAX);
    m_z   = clampi(m_z + dz, -127, 127);
    m_btn = int'(p[2:0]);
  endtask

  always @(posedge CLOCK) begin
    if (RESET) begin
      m_x = X_INIT; m_y = Y_INIT; m_z = 0; m_btn = 0;
      m_done = 0; m_reinit = 0; m_ovr = 0;
      m_on = 0; m_busy = 0; m_wd = 0;
    end else begin
      m_done = 0; m_reinit = 0;
      if (!m_on) begin
        if (iEn) m_on = 1;
      end else begin
        if (m_busy > 0 && iTrig) m_ovr = 1;
        if (!iEn) begin
          m_on = 0; m_busy = 0; m_wd = 0;
        end else if (m_busy == 0) begin
          if (iTrig) begin
            m_pkt = iData; m_busy = 3; m_wd = 0;
          end else if (m_wd == TO - 1) begin
            m_reinit = 1; m_wd = 0; m_on = 0;
          end else m_wd++;
        end else begin
          m_busy--;
          if (m_busy == 0) begin
            m_apply(m_pkt);
            m_done = 1;
          end
        end
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge CLOCK) begin
    if (chk_en) begin
      chk("oX",      32'(oX),         32'(m_x));
      chk("oY",      32'(oY),         32'(m_y));
      chk("oZ",      32'($signed(oZ)), 32'(m_z));
      chk("oBtn",    32'(oBtn),       32'(m_btn));
      chk("oDone",   32'(oDone),      32'(m_done));
      chk("oReinit", 32'(oReinit),    32'(m_reinit));
      chk("oOvr",    32'(oOvr),       32'(m_ovr));
      if (oReinit === 1'b1) reinit_cnt++;
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick(input int n);
    repeat (n) @(negedge CLOCK);
  endtask

  task automatic pkt(input logic [7:0] st, input logic [7:0] x, input logic [7:0] y,
                     input logic [3:0] z);
    iData = {4'h0, z, y, x, st};
    iTrig = 1'b1;
    tick(1);
    iTrig = 1'b0;
    iData = '0;
  endtask

  // Packet plus three edges: leaves us right as the update becomes visible.
  task automatic pkt_done(input logic [7:0] st, input logic [7:0] x, input logic [7:0] y,
                          input logic [3:0] z);
    pkt(st, x, y, z);
    tick(3);
  endtask

  logic [CW-1:0] sx, sy;
  logic [7:0]    sz;

  initial begin
    tick(2);
    chk_en = 1'b1;
    chk("rst_oX", 32'(oX), 32'd320);
    chk("rst_oY", 32'(oY), 32'd240);
    chk("rst_oZ", 32'(oZ), 32'd0);
    chk("rst_oOvr", 32'(oOvr), 32'd0);
    RESET = 1'b0;
    iEn = 1'b1;
    tick(2);

    // 1: basic move
    pkt_done(8'h08, 8'h05, 8'h03, 4'h0);
    chk("t1_done", 32'(oDone), 32'd1);
    chk("t1_oX",   32'(oX),    32'd325);
    chk("t1_oY",   32'(oY),    32'd237);
    chk("t1_oBtn", 32'(oBtn),  32'd0);

    // 2: walk to X=2 / Y=470, then clamp both edges
    pkt_done(8'h38, 8'h01, 8'h17, 4'h0);   // dx=-255, dy=-233
    chk("t2a_oX", 32'(oX), 32'd70);
    chk("t2a_oY", 32'(oY), 32'd470);
    pkt_done(8'h18, 8'hBC, 8'h00, 4'h0);   // dx=-68
    chk("t2b_oX", 32'(oX), 32'd2);
    pkt_done(8'h38, 8'hF6, 8'hE2, 4'h0);   // dx=-10, dy=-30
    chk("t2c_oX", 32'(oX), 32'd0);
    chk("t2c_oY", 32'(oY), 32'd479);

    // 3: X overflow ignores delta, L button; wheel saturation both ways
    pkt_done(8'h49, 8'h7F, 8'h00, 4'h0);
    chk("t3_oX",   32'(oX),   32'd0);
    chk("t3_oBtn", 32'(oBtn), 32'd1);
    pkt_done(8'h0C, 8'h00, 8'h00, 4'h8);   // M button, dz=-8
    chk("t3_oZneg", 32'($signed(oZ)), -32'sd8);
    chk("t3_oBtnM", 32'(oBtn), 32'd4);
    for (int i = 0; i < 20; i++) pkt_done(8'h08, 8'h00, 8'h00, 4'h7);
    chk("t3_oZsat", 32'(oZ), 32'd127);
    for (int i = 0; i < 40; i++) pkt_done(8'h08, 8'h00, 8'h00, 4'h8);
    chk("t3_oZmin", 32'($signed(oZ)), -32'sd127);
    pkt_done(8'h88, 8'h10, 8'h7F, 4'h0);   // Y overflow, dx=+16
    chk("t3_oXovfY", 32'(oX), 32'd16);
    chk("t3_oYovf",  32'(oY), 32'd479);

    // 4: watchdog fires once in a 150-cycle idle window, then stream resumes
    reinit_cnt = 0;
    tick(150);
    chk("t4_reinits", 32'(reinit_cnt), 32'd1);
    pkt_done(8'h0A, 8'h04, 8'h00, 4'h0);
    chk("t4_oX",   32'(oX),   32'd20);
    chk("t4_oBtn", 32'(oBtn), 32'd2);

    // iTrig while disabled is ignored and not an overrun
    iEn = 1'b0;
    tick(2);
    pkt(8'h08, 8'h10, 8'h00, 4'h0);
    tick(3);
    chk("wait_oOvr", 32'(oOvr), 32'd0);
    chk("wait_oX",   32'(oX),   32'd20);
    iEn = 1'b1;
    tick(2);

    // 5: back-to-back packets -> second dropped, sticky overrun
    pkt(8'h08, 8'h05, 8'h00, 4'h0);
    pkt(8'h08, 8'h50, 8'h00, 4'h0);
    tick(3);
    chk("t5_oX",   32'(oX),   32'd25);
    chk("t5_oOvr", 32'(oOvr), 32'd1);

    // iEn drop while in CLAMP aborts the packet
    sx = oX; sy = oY; sz = oZ;
    pkt(8'h08, 8'h30, 8'h30, 4'h1);
    tick(1);
    iEn = 1'b0;
    tick(5);
    chk("t5_abort_oX", 32'(oX), 32'(sx));
    chk("t5_abort_oY", 32'(oY), 32'(sy));
    chk("t5_abort_oZ", 32'(oZ), 32'(sz));
    chk("t5_abort_done", 32'(oDone), 32'd0);
    iEn = 1'b1;
    tick(2);

    // 6: reset during CALC
    pkt(8'h09, 8'h20, 8'h20, 4'h2);
    RESET = 1'b1;
    tick(1);
    chk("t6_oX",   32'(oX),   32'd320);
    chk("t6_oY",   32'(oY),   32'd240);
    chk("t6_oZ",   32'(oZ),   32'd0);
    chk("t6_oBtn", 32'(oBtn), 32'd0);
    chk("t6_oOvr", 32'(oOvr), 32'd0);
    RESET = 1'b0;
    tick(6);
    chk("t6_nodone", 32'(oX), 32'd320);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
